airi5c_hasti_sram_bridge: RTL and testbench
===========================================

AIRI5C_HASTI_SRAM_BRIDGE -- requirements
Module: airi5c_hasti_sram_bridge

Interface
REQ-001 SHALL have parameter MEM_AW, default 19, RAM word-address width.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h8000_0000, start of the mapped region.
REQ-003 SHALL have parameter BASE_MASK, default 32'hC000_0000, address bits compared against BASE_ADDR.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  sole clock, rising edge.
REQ-005 nreset  in  1  asynchronous active-low reset.
REQ-006 imem_haddr  in  32  instruction port address.
REQ-007 imem_htrans  in  2  instruction port transfer type.
REQ-008 imem_hwrite  in  1  instruction port write flag; writes are illegal.
REQ-009 imem_hsize  in  3  instruction port size.
REQ-010 imem_hrdata  out  32  instruction read data.
REQ-011 imem_hready  out  1  instruction port ready.
REQ-012 imem_hresp  out  1  instruction port response: 0 OKAY, 1 ERROR.
REQ-013 dmem_haddr  in  32  data port address.
REQ-014 dmem_htrans  in  2  data port transfer type.
REQ-015 dmem_hwrite  in  1  data port write flag.
REQ-016 dmem_hsize  in  3  data port size.
REQ-017 dmem_hwdata  in  32  data port write data, valid in the data phase.
REQ-018 dmem_hrdata  out  32  data port read data.
REQ-019 dmem_hready  out  1  data port ready.
REQ-020 dmem_hresp  out  1  data port response.
REQ-021 ram_a_addr  out  MEM_AW  RAM port A word address, read-only.
REQ-022 ram_a_rdata  in  32  RAM port A data, valid one cycle after the address is presented.
REQ-023 ram_b_addr  out  MEM_AW  RAM port B word address.
REQ-024 ram_b_we  out  4  RAM port B byte write enables.
REQ-025 ram_b_wdata  out  32  RAM port B write data.
REQ-026 ram_b_rdata  in  32  RAM port B data, one-cycle latency.

Function
REQ-027 A transfer SHALL be accepted only when htrans is NONSEQ or SEQ and that port's hready is 1; IDLE and BUSY SHALL always get a zero-wait OKAY.
REQ-028 Legal access: (haddr & BASE_MASK) == BASE_ADDR; hsize ≤ 2; naturally aligned (hsize 1: haddr[0]=0; hsize 2: haddr[1:0]=0); for imem, additionally hwrite=0.
REQ-029 ram_a_addr SHALL be combinationally driven from imem_haddr[MEM_AW+1:2]; legal imem reads SHALL complete with zero wait states, imem_hrdata = ram_a_rdata.
REQ-030 Data port states SHALL be IDLE, RD, WR, RD_STALL, ERR1 and ERR2.
REQ-031 RD: port B is addressed from dmem_haddr during the address phase; the data phase has zero wait states and dmem_hrdata = ram_b_rdata.
REQ-032 WR: address and byte enables are latched in the address phase; in the data phase port B writes dmem_hwdata with zero wait states.
REQ-033 Byte enables: hsize 0 gives 4'b0001<<haddr[1:0]; hsize 1 gives 4'b0011<<haddr[1:0]; hsize 2 gives 4'b1111.
REQ-034 Back-to-back writes SHALL sustain one transfer per cycle.
REQ-035 Read address phase during a WR data phase (port B busy): the read is accepted and RAM-addressed next cycle from the latched address (RD_STALL, hready=0), and data is returned one cycle later, i.e. exactly one wait state.
REQ-036 A read of a word being written in the preceding data phase SHALL return the newly written bytes.
REQ-037 Illegal transfer: ERR1 (hready=0, hresp=1), then ERR2 (hready=1, hresp=1); no RAM write SHALL occur.
REQ-038 Outside data phases, ram_b_we SHALL be 0; hrdata SHALL be 0 during error and idle cycles.

Reset
REQ-039 When nreset is low, all state SHALL clear asynchronously: FSM IDLE, hready=1, hresp=0, ram_b_we=0, latched address 0.
REQ-040 Reset asserted mid-transfer SHALL abort the transfer without completing the write; the first accepted transfer after release SHALL behave normally.

Configuration
REQ-041 Macro AIRI5C_SRAM_BRIDGE_ERR_EN: defined means REQ-037 applies.
REQ-042 Without it, illegal transfers SHALL complete as zero-wait OKAY with no RAM write, reads returning 0, and ERR1/ERR2 SHALL be absent.

Verification
REQ-043 dmem SW 0x8000_0010 = 0xDEADBEEF, then LW same address -> one wait state, hrdata 0xDEADBEEF, hresp 0.
REQ-044 SB 0x8000_0013 = 0xAA over word 0x11223344 -> ram_b_we 4'b1000, readback 0xAA223344.
REQ-045 Four consecutive SW -> four cycles, hready constantly 1.
REQ-046 With ERR_EN, LW 0x0000_0000 or imem write -> hready 0/1 and hresp 1/1 over two cycles, ram_b_we 0; without ERR_EN -> OKAY, hrdata 0.
REQ-047 nreset pulsed low during a SW data phase -> ram_b_we 0, hready 1 immediately.

Source files
------------

// File: rtl/airi5c_hasti_sram_bridge.sv
// Two AHB-Lite ports onto a dual-port SRAM: imem is read-only on port A, dmem reads/writes on port B.
// Define AIRI5C_SRAM_BRIDGE_ERR_EN to answer illegal transfers with a two-cycle ERROR response.
module airi5c_hasti_sram_bridge #(
    parameter int unsigned MEM_AW    = 19,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter logic [31:0] BASE_MASK = 32'hC000_0000
) (
    input  logic              clk,
    input  logic              nreset,

    input  logic [31:0]       imem_haddr,
    input  logic [1:0]        imem_htrans,
    input  logic              imem_hwrite,
    input  logic [2:0]        imem_hsize,
    output logic [31:0]       imem_hrdata,
    output logic              imem_hready,
    output logic              imem_hresp,

    input  logic [31:0]       dmem_haddr,
    input  logic [1:0]        dmem_htrans,
    input  logic              dmem_hwrite,
    input  logic [2:0]        dmem_hsize,
    input  logic [31:0]       dmem_hwdata,
    output logic [31:0]       dmem_hrdata,
    output logic              dmem_hready,
    output logic              dmem_hresp,

    output logic [MEM_AW-1:0] ram_a_addr,
    input  logic [31:0]       ram_a_rdata,
    output logic [MEM_AW-1:0] ram_b_addr,
    output logic [3:0]        ram_b_we,
    output logic [31:0]       ram_b_wdata,
    input  logic [31:0]       ram_b_rdata
);

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        RD_STALL
`ifdef AIRI5C_SRAM_BRIDGE_ERR_EN
        , ERR1
        , ERR2
`endif
    } dstate_e;

    // In the mapped window, size up to a word, naturally aligned.
    function automatic logic legal_f(input logic [31:0] a, input logic [2:0] s);
        logic align;
        case (s)
            3'd0:    align = 1'b1;
            3'd1:    align = ~a[0];
            3'd2:    align = (a[1:0] == 2'b00);
            default: align = 1'b0;
        endcase
        return align && ((a & BASE_MASK) == BASE_ADDR);
    endfunction

    function automatic logic [3:0] be_f(input logic [1:0] a, input logic [2:0] s);
        case (s)
            3'd0:    return 4'b0001 << a;
            3'd1:    return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

    // ---------------- instruction port ----------------
    logic i_accept;
    logic i_legal;
    logic i_rd_q;

    assign i_accept   = imem_hready && (imem_htrans == HTRANS_NONSEQ || imem_htrans == HTRANS_SEQ);
    assign i_legal    = legal_f(imem_haddr, imem_hsize) && !imem_hwrite;
    assign ram_a_addr = imem_haddr[MEM_AW+1:2];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) i_rd_q <= 1'b0;
        else         i_rd_q <= i_accept && i_legal;
    end

    assign imem_hrdata = i_rd_q ? ram_a_rdata : 32'h0;

`ifdef AIRI5C_SRAM_BRIDGE_ERR_EN
    // hready low marks the first error cycle; hresp stays high into the second.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            imem_hready <= 1'b1;
            imem_hresp  <= 1'b0;
        end else begin
            imem_hready <= !(i_accept && !i_legal);
            imem_hresp  <= (i_accept && !i_legal) || !imem_hready;
        end
    end
`else
    assign imem_hready = 1'b1;
    assign imem_hresp  = 1'b0;
`endif

    // ---------------- data port ----------------
    dstate_e           state_q, state_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [3:0]        we_d;
    logic              hready_d;
    logic              hresp_d;
    logic              d_accept;
    logic              d_legal;
    logic [MEM_AW-1:0] d_word;

    assign d_accept = dmem_hready && (dmem_htrans == HTRANS_NONSEQ || dmem_htrans == HTRANS_SEQ);
    assign d_legal  = legal_f(dmem_haddr, dmem_hsize);
    assign d_word   = dmem_haddr[MEM_AW+1:2];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            ram_b_we    <= 4'b0000;
            dmem_hready <= 1'b1;
            dmem_hresp  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            ram_b_we    <= we_d;
            dmem_hready <= hready_d;
            dmem_hresp  <= hresp_d;
        end
    end

    // Registered outputs are computed for the state being entered.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = 4'b0000;
        hready_d = 1'b1;
        hresp_d  = 1'b0;
        case (state_q)
`ifdef AIRI5C_SRAM_BRIDGE_ERR_EN
            ERR1: begin
                state_d = ERR2;
                hresp_d = 1'b1;
            end
`endif
            RD_STALL: state_d = RD;
            default: begin
                if (!d_accept) begin
                    state_d = IDLE;
                end else if (!d_legal) begin
`ifdef AIRI5C_SRAM_BRIDGE_ERR_EN
                    state_d  = ERR1;
                    hready_d = 1'b0;
                    hresp_d  = 1'b1;
`else
                    state_d  = IDLE;
`endif
                end else if (dmem_hwrite) begin
                    state_d = WR;
                    addr_d  = d_word;
                    we_d    = be_f(dmem_haddr[1:0], dmem_hsize);
                end else if (state_q == WR) begin
                    // Port B is busy with the write data phase; replay the read next cycle.
                    state_d  = RD_STALL;
                    addr_d   = d_word;
                    hready_d = 1'b0;
                end else begin
                    state_d = RD;
                end
            end
        endcase
    end

    assign ram_b_addr  = (state_q == WR || state_q == RD_STALL) ? addr_q : d_word;
    assign ram_b_wdata = dmem_hwdata;
    assign dmem_hrdata = (state_q == RD) ? ram_b_rdata : 32'h0;

endmodule

// File: tb/tb_airi5c_hasti_sram_bridge.sv
// Directed bench for airi5c_hasti_sram_bridge with a behavioural dual-port SRAM.
module tb_airi5c_hasti_sram_bridge;

    localparam int unsigned MEM_AW = 19;

    logic              clk = 1'b0;
    logic              nreset = 1'b1;
    logic [31:0]       imem_haddr = 32'h0;
    logic [1:0]        imem_htrans = 2'b00;
    logic              imem_hwrite = 1'b0;
    logic [2:0]        imem_hsize = 3'd2;
    logic [31:0]       imem_hrdata;
    logic              imem_hready;
    logic              imem_hresp;
    logic [31:0]       dmem_haddr = 32'h0;
    logic [1:0]        dmem_htrans = 2'b00;
    logic              dmem_hwrite = 1'b0;
    logic [2:0]        dmem_hsize = 3'd2;
    logic [31:0]       dmem_hwdata = 32'h0;
    logic [31:0]       dmem_hrdata;
    logic              dmem_hready;
    logic              dmem_hresp;
    logic [MEM_AW-1:0] ram_a_addr;
    logic [31:0]       ram_a_rdata;
    logic [MEM_AW-1:0] ram_b_addr;
    logic [3:0]        ram_b_we;
    logic [31:0]       ram_b_wdata;
    logic [31:0]       ram_b_rdata;

    logic [31:0] mem [256] = '{default: 32'h0};

    int total = 0;
    int bad   = 0;

    airi5c_hasti_sram_bridge #(.MEM_AW(MEM_AW)) dut (
        .clk         (clk),
        .nreset      (nreset),
        .imem_haddr  (imem_haddr),
        .imem_htrans (imem_htrans),
        .imem_hwrite (imem_hwrite),
        .imem_hsize  (imem_hsize),
        .imem_hrdata (imem_hrdata),
        .imem_hready (imem_hready),
        .imem_hresp  (imem_hresp),
        .dmem_haddr  (dmem_haddr),
        .dmem_htrans (dmem_htrans),
        .dmem_hwrite (dmem_hwrite),
        .dmem_hsize  (dmem_hsize),
        .dmem_hwdata (dmem_hwdata),
        .dmem_hrdata (dmem_hrdata),
        .dmem_hready (dmem_hready),
        .dmem_hresp  (dmem_hresp),
        .ram_a_addr  (ram_a_addr),
        .ram_a_rdata (ram_a_rdata),
        .ram_b_addr  (ram_b_addr),
        .ram_b_we    (ram_b_we),
        .ram_b_wdata (ram_b_wdata),
        .ram_b_rdata (ram_b_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM, one-cycle read latency, read-before-write on port B.
    always @(posedge clk) begin
        ram_a_rdata <= mem[8'(ram_a_addr)];
        ram_b_rdata <= mem[8'(ram_b_addr)];
        for (int k = 0; k < 4; k++)
            if (ram_b_we[k]) mem[8'(ram_b_addr)][8*k +: 8] <= ram_b_wdata[8*k +: 8];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic d_req(input logic [31:0] a, input logic w, input logic [2:0] s);
        dmem_haddr  = a;
        dmem_hwrite = w;
        dmem_hsize  = s;
        dmem_htrans = 2'b10;
    endtask

    task automatic d_idle();
        dmem_htrans = 2'b00;
        dmem_hwrite = 1'b0;
    endtask

    task automatic test_reset();
        #1 nreset = 1'b0;
        #2;
        total++; if (dmem_hready !== 1'b1) begin bad++; $display("FAIL rst_dhready got=%b exp=1", dmem_hready); end
        total++; if (dmem_hresp !== 1'b0) begin bad++; $display("FAIL rst_dhresp got=%b exp=0", dmem_hresp); end
        total++; if (ram_b_we !== 4'b0000) begin bad++; $display("FAIL rst_we got=%b exp=0000", ram_b_we); end
        total++; if (dmem_hrdata !== 32'h0) begin bad++; $display("FAIL rst_dhrdata got=%h exp=0", dmem_hrdata); end
        total++; if (imem_hready !== 1'b1 || imem_hresp !== 1'b0) begin bad++; $display("FAIL rst_imem got=%b%b exp=10", imem_hready, imem_hresp); end
        tick();
        tick();
        nreset = 1'b1;
    endtask

    task automatic test_write_read();
        tick(); d_req(32'h8000_0010, 1'b1, 3'd2);
        total++; if (dmem_hready !== 1'b1) begin bad++; $display("FAIL wr_addr_hready got=%b exp=1", dmem_hready); end
        tick(); dmem_hwdata = 32'hDEAD_BEEF; d_req(32'h8000_0010, 1'b0, 3'd2);
        total++; if (ram_b_we !== 4'b1111) begin bad++; $display("FAIL wr_we got=%b exp=1111", ram_b_we); end
        total++; if (ram_b_addr !== 19'h4) begin bad++; $display("FAIL wr_addr got=%h exp=4", ram_b_addr); end
        total++; if (dmem_hready !== 1'b1) begin bad++; $display("FAIL wr_data_hready got=%b exp=1", dmem_hready); end
        tick(); d_idle();
        total++; if (dmem_hready !== 1'b0) begin bad++; $display("FAIL stall_hready got=%b exp=0", dmem_hready); end
        total++; if (ram_b_we !== 4'b0000) begin bad++; $display("FAIL stall_we got=%b exp=0000", ram_b_we); end
        total++; if (ram_b_addr !== 19'h4) begin bad++; $display("FAIL stall_addr got=%h exp=4", ram_b_addr); end
        tick();
        total++; if (dmem_hready !== 1'b1 || dmem_hresp !== 1'b0) begin bad++; $display("FAIL rd_resp got=%b%b exp=10", dmem_hready, dmem_hresp); end
        total++; if (dmem_hrdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_data got=%h exp=deadbeef", dmem_hrdata); end
        tick();
        total++; if (dmem_hrdata !== 32'h0) begin bad++; $display("FAIL idle_hrdata got=%h exp=0", dmem_hrdata); end
    endtask

    task automatic test_byte_write();
        tick(); d_req(32'h8000_0010, 1'b1, 3'd2);
        tick(); dmem_hwdata = 32'h1122_3344; d_req(32'h8000_0013, 1'b1, 3'd0);
        tick(); dmem_hwdata = 32'hAA00_0000; d_req(32'h8000_0010, 1'b0, 3'd2);
        total++; if (ram_b_we !== 4'b1000) begin bad++; $display("FAIL sb_we got=%b exp=1000", ram_b_we); end
        tick(); d_idle();
        tick();
        total++; if (dmem_hrdata !== 32'hAA22_3344) begin bad++; $display("FAIL sb_readback got=%h exp=aa223344", dmem_hrdata); end
        tick(); d_req(32'h8000_0016, 1'b1, 3'd1);
        tick(); dmem_hwdata = 32'h5566_0000; d_idle();
        total++; if (ram_b_we !== 4'b1100) begin bad++; $display("FAIL sh_we got=%b exp=1100", ram_b_we); end
        tick();
        total++; if (mem[5] !== 32'h5566_0000) begin bad++; $display("FAIL sh_mem got=%h exp=55660000", mem[5]); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i > 0) dmem_hwdata = 32'hA0A0_0000 + 32'(i - 1);
            if (i < 4) d_req(32'h8000_0020 + 32'(4 * i), 1'b1, 3'd2);
            else d_idle();
            total++; if (dmem_hready !== 1'b1) begin bad++; $display("FAIL b2b_hready_%0d got=%b exp=1", i, dmem_hready); end
            if (i > 0) begin
                total++; if (ram_b_we !== 4'b1111 || ram_b_addr !== 19'(8 + i - 1)) begin bad++; $display("FAIL b2b_wr_%0d got=%b/%h exp=1111/%h", i, ram_b_we, ram_b_addr, 8 + i - 1); end
            end
        end
        tick(); d_req(32'h8000_0024, 1'b0, 3'd2);
        tick(); d_idle();
        total++; if (dmem_hready !== 1'b1 || dmem_hrdata !== 32'hA0A0_0001) begin bad++; $display("FAIL b2b_read got=%b/%h exp=1/a0a00001", dmem_hready, dmem_hrdata); end
        total++; if (mem[11] !== 32'hA0A0_0003) begin bad++; $display("FAIL b2b_mem got=%h exp=a0a00003", mem[11]); end
    endtask

    task automatic test_idle_busy();
        tick(); d_req(32'h0000_0001, 1'b1, 3'd2); dmem_htrans = 2'b01;
        tick(); d_idle();
        total++; if (dmem_hready !== 1'b1 || dmem_hresp !== 1'b0 || ram_b_we !== 4'b0000) begin bad++; $display("FAIL busy_okay got=%b%b/%b exp=10/0000", dmem_hready, dmem_hresp, ram_b_we); end
    endtask

    task automatic test_illegal();
        tick(); d_req(32'h0000_0000, 1'b0, 3'd2);
        tick(); d_idle();
`ifdef AIRI5C_SRAM_BRIDGE_ERR_EN
        total++; if (dmem_hready !== 1'b0 || dmem_hresp !== 1'b1) begin bad++; $display("FAIL err1 got=%b%b exp=01", dmem_hready, dmem_hresp); end
`else
        total++; if (dmem_hready !== 1'b1 || dmem_hresp !== 1'b0) begin bad++; $display("FAIL ill_okay got=%b%b exp=10", dmem_hready, dmem_hresp); end
`endif
        total++; if (dmem_hrdata !== 32'h0 || ram_b_we !== 4'b0000) begin bad++; $display("FAIL ill_data got=%h/%b exp=0/0000", dmem_hrdata, ram_b_we); end
        tick();
`ifdef AIRI5C_SRAM_BRIDGE_ERR_EN
        total++; if (dmem_hready !== 1'b1 || dmem_hresp !== 1'b1) begin bad++; $display("FAIL err2 got=%b%b exp=11", dmem_hready, dmem_hresp); end
`endif
        tick();
        total++; if (dmem_hresp !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", dmem_hresp); end
        // Misaligned word store must leave memory untouched.
        tick(); d_req(32'h8000_0012, 1'b1, 3'd2);
        tick(); dmem_hwdata = 32'hFFFF_FFFF; d_idle();
        total++; if (ram_b_we !== 4'b0000) begin bad++; $display("FAIL mis_we got=%b exp=0000", ram_b_we); end
        tick(); tick();
        total++; if (mem[4] !== 32'hAA22_3344) begin bad++; $display("FAIL mis_mem got=%h exp=aa223344", mem[4]); end
    endtask

    task automatic test_imem();
        tick(); imem_haddr = 32'h8000_0010; imem_hwrite = 1'b0; imem_hsize = 3'd2; imem_htrans = 2'b10;
        total++; if (ram_a_addr !== 19'h4) begin bad++; $display("FAIL imem_addr got=%h exp=4", ram_a_addr); end
        tick(); imem_htrans = 2'b00;
        total++; if (imem_hready !== 1'b1 || imem_hrdata !== 32'hAA22_3344) begin bad++; $display("FAIL imem_read got=%b/%h exp=1/aa223344", imem_hready, imem_hrdata); end
        tick(); imem_hwrite = 1'b1; imem_htrans = 2'b10;
        tick(); imem_htrans = 2'b00; imem_hwrite = 1'b0;
`ifdef AIRI5C_SRAM_BRIDGE_ERR_EN
        total++; if (imem_hready !== 1'b0 || imem_hresp !== 1'b1) begin bad++; $display("FAIL imem_err1 got=%b%b exp=01", imem_hready, imem_hresp); end
        tick();
        total++; if (imem_hready !== 1'b1 || imem_hresp !== 1'b1) begin bad++; $display("FAIL imem_err2 got=%b%b exp=11", imem_hready, imem_hresp); end
`else
        total++; if (imem_hready !== 1'b1 || imem_hresp !== 1'b0) begin bad++; $display("FAIL imem_wr_okay got=%b%b exp=10", imem_hready, imem_hresp); end
`endif
        total++; if (imem_hrdata !== 32'h0) begin bad++; $display("FAIL imem_wr_data got=%h exp=0", imem_hrdata); end
        tick();
        total++; if (imem_hresp !== 1'b0) begin bad++; $display("FAIL imem_clear got=%b exp=0", imem_hresp); end
    endtask

    task automatic test_reset_mid();
        tick(); d_req(32'h8000_0030, 1'b1, 3'd2);
        tick(); dmem_hwdata = 32'h5555_5555; d_idle();
        total++; if (ram_b_we !== 4'b1111) begin bad++; $display("FAIL rm_we_before got=%b exp=1111", ram_b_we); end
        #1 nreset = 1'b0;
        #1;
        total++; if (ram_b_we !== 4'b0000 || dmem_hready !== 1'b1) begin bad++; $display("FAIL rm_abort got=%b/%b exp=0000/1", ram_b_we, dmem_hready); end
        tick(); tick();
        nreset = 1'b1;
        tick();
        total++; if (mem[12] !== 32'h0) begin bad++; $display("FAIL rm_mem got=%h exp=0", mem[12]); end
        d_req(32'h8000_0030, 1'b1, 3'd2);
        tick(); dmem_hwdata = 32'h1234_5678; d_req(32'h8000_0030, 1'b0, 3'd2);
        total++; if (ram_b_we !== 4'b1111) begin bad++; $display("FAIL rm_after_we got=%b exp=1111", ram_b_we); end
        tick(); d_idle();
        tick();
        total++; if (dmem_hrdata !== 32'h1234_5678) begin bad++; $display("FAIL rm_after_rd got=%h exp=12345678", dmem_hrdata); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_write();
        test_back_to_back();
        test_idle_busy();
        test_illegal();
        test_imem();
        test_reset_mid();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
